// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions: default widths, the "no destination" index and the
// broadcast record that reservation stations snoop.
package cdb_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_TAG_W  = 3;
  localparam int unsigned DEF_REG_W  = 3;

  // Register index 0 marks a result with no register-file writeback (e.g. stores).
  localparam int unsigned NO_DEST = 0;

  typedef struct packed {
    logic                  valid;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_REG_W-1:0]  dest;
    logic [DEF_DATA_W-1:0] data;
  } cdb_bcast_t;

  function automatic logic is_writeback(input logic [DEF_REG_W-1:0] dest);
    return dest != DEF_REG_W'(NO_DEST);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping around.
// The pointer register is owned by the instantiating module.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] w_scan;

  // NREQ is a power of two, so the PTR_W-bit sum wraps naturally.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_scan  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_scan = i_ptr + PTR_W'(k);
      if (!o_any && i_req[w_scan]) begin
        o_any           = 1'b1;
        o_grant[w_scan] = 1'b1;
        o_idx           = w_scan;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant among result producers, one registered
// broadcast per cycle that doubles as the register-file write port.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned REG_W  = DEF_REG_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*TAG_W-1:0]     req_tag,
  input  logic [NREQ*REG_W-1:0]     req_dest,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [$clog2(NREQ)-1:0]   cdb_src,
  output logic                      rf_we,
  output logic [REG_W-1:0]          rf_addr,
  output logic [DATA_W-1:0]         rf_data
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]  r_ptr;
  logic              r_valid;
  logic [TAG_W-1:0]  r_tag;
  logic [REG_W-1:0]  r_dest;
  logic [DATA_W-1:0] r_data;
  logic [PTR_W-1:0]  r_src;

  logic [NREQ-1:0]   w_grant;
  logic [PTR_W-1:0]  w_idx;
  logic              w_any;
  logic              w_open;
  logic              w_hs;

  logic [TAG_W-1:0]  w_tag_arr  [NREQ];
  logic [REG_W-1:0]  w_dest_arr [NREQ];
  logic [DATA_W-1:0] w_data_arr [NREQ];

  for (genvar gi = 0; gi < int'(NREQ); gi++) begin : g_unpack
    assign w_tag_arr[gi]  = req_tag[gi*TAG_W +: TAG_W];
    assign w_dest_arr[gi] = req_dest[gi*REG_W +: REG_W];
    assign w_data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Reset and flush both suppress the grant itself, so requesters keep their payload.
  assign w_open    = !reset && !flush;
  assign w_hs      = w_open && w_any;
  assign req_ready = w_open ? w_grant : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_dest  <= '0;
      r_data  <= '0;
      r_src   <= '0;
    end else begin
      r_valid <= w_hs;
      if (w_hs) begin
        r_ptr  <= w_idx + PTR_W'(1);
        r_tag  <= w_tag_arr[w_idx];
        r_dest <= w_dest_arr[w_idx];
        r_data <= w_data_arr[w_idx];
        r_src  <= w_idx;
      end
    end
  end

  assign cdb_valid = r_valid;
  assign cdb_tag   = r_tag;
  assign cdb_data  = r_data;
  assign cdb_src   = r_src;
  assign rf_we     = r_valid && (r_dest != REG_W'(NO_DEST));
  assign rf_addr   = r_dest;
  assign rf_data   = r_data;

  a_grant_onehot: assert property (@(posedge clock) $onehot0(req_ready));
  a_grant_subset: assert property (@(posedge clock) (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: scenario tasks plus a broadcast scoreboard.
module tb_cdb_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 16;
  localparam int TAG_W  = 3;
  localparam int REG_W  = 3;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ*REG_W-1:0]  req_dest;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   cdb_valid;
  logic [TAG_W-1:0]       cdb_tag;
  logic [DATA_W-1:0]      cdb_data;
  logic [1:0]             cdb_src;
  logic                   rf_we;
  logic [REG_W-1:0]       rf_addr;
  logic [DATA_W-1:0]      rf_data;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
    logic [1:0]        src;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   m_ptr  = 0;

  cdb_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .TAG_W(TAG_W), .REG_W(REG_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_tag  (req_tag),
    .req_dest (req_dest),
    .req_data (req_data),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .cdb_src  (cdb_src),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int scan(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [REG_W-1:0] d,
                         input logic [DATA_W-1:0] x);
    req_tag[i*TAG_W +: TAG_W]    = t;
    req_dest[i*REG_W +: REG_W]   = d;
    req_data[i*DATA_W +: DATA_W] = x;
  endtask

  // Predict this cycle's broadcast from the current inputs, then advance to the next negedge.
  task automatic clk_cycle();
    exp_t e;
    int   g;
    e = '0;
    if (reset) begin
      m_ptr = 0;
    end else if (!flush) begin
      g = scan(req_valid, m_ptr);
      if (g >= 0) begin
        e.valid = 1'b1;
        e.tag   = req_tag[g*TAG_W +: TAG_W];
        e.dest  = req_dest[g*REG_W +: REG_W];
        e.data  = req_data[g*DATA_W +: DATA_W];
        e.src   = 2'(g);
        m_ptr   = (g + 1) % NREQ;
      end
    end
    sb.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  always @(posedge clock) begin
    exp_t me;
    #1;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow: got empty scoreboard want an entry");
    end else begin
      me = sb.pop_front();
      if (cdb_valid !== me.valid) begin
        n_fail++;
        $display("FAIL sb_valid: got %b want %b", cdb_valid, me.valid);
      end
      n_cmp++;
      if (rf_we !== (me.valid && me.dest != 0)) begin
        n_fail++;
        $display("FAIL sb_rf_we: got %b want %b", rf_we, me.valid && me.dest != 0);
      end
      if (me.valid) begin
        n_cmp++;
        if (cdb_tag !== me.tag || cdb_data !== me.data || cdb_src !== me.src) begin
          n_fail++;
          $display("FAIL sb_payload: got tag=%0d data=%h src=%0d want tag=%0d data=%h src=%0d",
                   cdb_tag, cdb_data, cdb_src, me.tag, me.data, me.src);
        end
        if (me.dest != 0) begin
          n_cmp++;
          if (rf_addr !== me.dest || rf_data !== me.data) begin
            n_fail++;
            $display("FAIL sb_rf_port: got addr=%0d data=%h want addr=%0d data=%h",
                     rf_addr, rf_data, me.dest, me.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; req_valid = 4'b1111;
    req_tag = '0; req_dest = '0; req_data = '0;
    #1; n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    clk_cycle();
    n_cmp++;
    if (cdb_tag !== '0 || cdb_data !== '0 || cdb_src !== '0 || rf_addr !== '0 || rf_data !== '0)
    begin
      n_fail++;
      $display("FAIL reset_fields: got tag=%0d data=%h src=%0d addr=%0d rfd=%h want all 0",
               cdb_tag, cdb_data, cdb_src, rf_addr, rf_data);
    end
    reset = 1'b0; req_valid = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      #1; n_cmp++;
      if (req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL idle_ready: got %b want 0000 (cycle %0d)", req_ready, c);
      end
      clk_cycle();
    end
  endtask

  task automatic test_single();
    set_req(2, 3'd5, 3'd3, 16'h00A5);
    req_valid = 4'b0100;
    #1; n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    clk_cycle();
    n_cmp++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 3'd5 || cdb_data !== 16'h00A5 || cdb_src !== 2'd2 ||
        rf_we !== 1'b1 || rf_addr !== 3'd3) begin
      n_fail++;
      $display("FAIL single_bcast: got v=%b tag=%0d data=%h src=%0d we=%b addr=%0d want 1 5 00a5 2 1 3",
               cdb_valid, cdb_tag, cdb_data, cdb_src, rf_we, rf_addr);
    end
    req_valid = 4'b0000;
  endtask

  // Pointer left at 3: with requesters 0 and 3 pending, 3 wins and the pointer wraps to 0.
  task automatic test_wrap();
    set_req(0, 3'd1, 3'd1, 16'h1000);
    set_req(3, 3'd7, 3'd4, 16'h3000);
    req_valid = 4'b1001;
    #1; n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL wrap_ready: got %b want 1000", req_ready);
    end
    clk_cycle();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] want;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i + 1), 3'(i + 1), 16'(16'hB000 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      want = 4'b0001 << (k % NREQ);
      #1; n_cmp++;
      if (req_ready !== want) begin
        n_fail++; $display("FAIL rr_grant: got %b want %b (cycle %0d)", req_ready, want, k);
      end
      clk_cycle();
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_store();
    set_req(1, 3'd2, 3'd0, 16'h0040);
    req_valid = 4'b0010;
    #1; n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL store_ready: got %b want 0010", req_ready);
    end
    clk_cycle();
    n_cmp++;
    if (cdb_valid !== 1'b1 || rf_we !== 1'b0 || cdb_data !== 16'h0040) begin
      n_fail++;
      $display("FAIL store_bcast: got v=%b we=%b data=%h want 1 0 0040", cdb_valid, rf_we, cdb_data);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_flush();
    set_req(0, 3'd3, 3'd2, 16'hAAAA);
    req_valid = 4'b0001;
    clk_cycle();
    set_req(1, 3'd6, 3'd5, 16'h1234);
    req_valid = 4'b0010; flush = 1'b1;
    #1; n_cmp++;
    if (req_ready !== 4'b0000 || cdb_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: got ready=%b v=%b want ready=0000 v=1", req_ready, cdb_valid);
    end
    clk_cycle();
    flush = 1'b0;
    #1; n_cmp++;
    if (req_ready !== 4'b0010 || cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: got ready=%b v=%b want ready=0010 v=0", req_ready, cdb_valid);
    end
    clk_cycle();
    req_valid = 4'b0000;
    n_cmp++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_data !== 16'h1234 || cdb_tag !== 3'd6) begin
      n_fail++;
      $display("FAIL flush_regrant: got v=%b src=%0d data=%h tag=%0d want 1 1 1234 6",
               cdb_valid, cdb_src, cdb_data, cdb_tag);
    end
    clk_cycle();
  endtask

  task automatic test_reset_mid();
    set_req(3, 3'd4, 3'd6, 16'h0333);
    set_req(0, 3'd5, 3'd7, 16'h0111);
    req_valid = 4'b1000; reset = 1'b1;
    #1; n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_ready: got %b want 0000", req_ready);
    end
    clk_cycle();
    flush = 1'b1;
    #1; n_cmp++;
    if (req_ready !== 4'b0000 || cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstflush: got ready=%b v=%b want ready=0000 v=0", req_ready, cdb_valid);
    end
    clk_cycle();
    reset = 1'b0; flush = 1'b0; req_valid = 4'b1001;
    #1; n_cmp++;
    if (req_ready !== 4'b0001 || cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_ptr0: got ready=%b v=%b want ready=0001 v=0", req_ready, cdb_valid);
    end
    clk_cycle();
    req_valid = 4'b1000;
    #1; n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL rstmid_req3: got %b want 1000", req_ready);
    end
    clk_cycle();
    req_valid = 4'b0000;
  endtask

  task automatic test_back_to_back();
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      set_req(2, 3'(k + 2), 3'(k), 16'(16'hC0DE + k));
      #1; n_cmp++;
      if (req_ready !== 4'b0100) begin
        n_fail++; $display("FAIL b2b_ready: got %b want 0100 (cycle %0d)", req_ready, k);
      end
      clk_cycle();
    end
    req_valid = 4'b0000;
    clk_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_store();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    clk_cycle();
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
